// File: rtl/i2c_slave_byte_engine.sv
// I2C slave bit/byte engine: START/STOP detection, address match, byte shifting and ACK generation.
// Optional general-call (address 8'h00) acceptance is enabled by defining I2C_GEN_CALL_EN.
module i2c_slave_byte_engine #(
    parameter logic [6:0] SLV_ADDR = 7'h2A
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       rx_edge,
    input  logic       tx_edge,
    input  logic [7:0] tx_data,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_load,
    output logic       addr_match,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_dly_q, sda_dly_d;
    logic       ack_q, ack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       addr_match_q, addr_match_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    logic start_cond, stop_cond, gen_call, addr_ok;

    assign start_cond = scl_in & sda_dly_q & ~sda_in;
    assign stop_cond  = scl_in & ~sda_dly_q & sda_in;

`ifdef I2C_GEN_CALL_EN
    assign gen_call = (shreg_q == 8'h00);
`else
    assign gen_call = 1'b0;
`endif
    assign addr_ok = (shreg_q[7:1] == SLV_ADDR) | gen_call;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        sda_dly_d    = sda_in;
        ack_d        = ack_q;
        sda_oe_d     = sda_oe_q;
        rx_valid_d   = 1'b0;
        tx_load_d    = 1'b0;
        addr_match_d = 1'b0;
        rw_d         = rw_q;

        if (stop_cond) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (start_cond) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: sda_oe_d = 1'b0;
                ADDR: begin
                    if (rx_edge && bit_cnt_q != 4'd8) begin
                        shreg_d   = {shreg_q[6:0], sda_in};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (tx_edge && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (addr_ok) begin
                            state_d      = ADDR_ACK;
                            sda_oe_d     = 1'b1;
                            rw_d         = shreg_q[0];
                            addr_match_d = 1'b1;
                        end else begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (tx_edge) begin
                        bit_cnt_d = 4'd0;
                        if (!rw_q) begin
                            state_d  = RX_DATA;
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d   = TX_DATA;
                            tx_load_d = 1'b1;
                            shreg_d   = tx_data;
                            sda_oe_d  = ~tx_data[7];
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_edge && bit_cnt_q != 4'd8) begin
                        shreg_d   = {shreg_q[6:0], sda_in};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = {shreg_q[6:0], sda_in};
                            rx_valid_d = 1'b1;
                        end
                    end else if (tx_edge && bit_cnt_q == 4'd8) begin
                        state_d  = RX_ACK;
                        sda_oe_d = 1'b1;
                    end
                end
                RX_ACK: begin
                    if (tx_edge) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                    end
                end
                TX_DATA: begin
                    if (rx_edge && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (tx_edge) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d  = TX_ACK;
                            sda_oe_d = 1'b0;
                            ack_d    = 1'b0;
                        end else if (bit_cnt_q != 4'd0) begin
                            // Bit 7 went out on entry; each later fall presents the next bit down.
                            sda_oe_d = ~shreg_q[6];
                            shreg_d  = {shreg_q[6:0], 1'b0};
                        end
                    end
                end
                TX_ACK: begin
                    if (rx_edge) begin
                        if (sda_in) begin
                            state_d = WAIT_STOP;
                        end else begin
                            ack_d = 1'b1;
                        end
                    end else if (tx_edge && ack_q) begin
                        state_d   = TX_DATA;
                        bit_cnt_d = 4'd0;
                        tx_load_d = 1'b1;
                        shreg_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                    end
                end
                WAIT_STOP: sda_oe_d = 1'b0;
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            shreg_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            sda_dly_q    <= 1'b1;
            ack_q        <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            tx_load_q    <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            sda_dly_q    <= sda_dly_d;
            ack_q        <= ack_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            tx_load_q    <= tx_load_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_load    = tx_load_q;
    assign addr_match = addr_match_q;
    assign rw         = rw_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Directed bench for i2c_slave_byte_engine: acts as the I2C master on a wired-AND SDA line.
module tb_i2c_slave_byte_engine;

`ifdef I2C_GEN_CALL_EN
    localparam logic GEN = 1'b1;
`else
    localparam logic GEN = 1'b0;
`endif

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_edge = 1'b0;
    logic       tx_edge = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_in;
    logic       sda_oe, rx_valid, tx_load, addr_match, rw, busy;
    logic [7:0] rx_data;

    int passed = 0;
    int total  = 0;
    int rxv_cnt = 0, txl_cnt = 0, am_cnt = 0, oe_cnt = 0;

    always #5 pclk = ~pclk;

    // Open-drain bus: either side can pull low.
    assign sda_in = sda_m & ~sda_oe;

    i2c_slave_byte_engine dut (
        .pclk(pclk), .preset(preset), .scl_in(scl_in), .sda_in(sda_in),
        .rx_edge(rx_edge), .tx_edge(tx_edge), .tx_data(tx_data),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid), .tx_load(tx_load),
        .addr_match(addr_match), .rw(rw), .busy(busy)
    );

    always @(posedge pclk) begin
        if (rx_valid)   rxv_cnt++;
        if (tx_load)    txl_cnt++;
        if (addr_match) am_cnt++;
        if (sda_oe)     oe_cnt++;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic scl_rise();
        scl_in = 1'b1; rx_edge = 1'b1; tick(); rx_edge = 1'b0; tick();
    endtask

    task automatic scl_fall();
        scl_in = 1'b0; tx_edge = 1'b1; tick(); tx_edge = 1'b0; tick();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; tick();
        scl_rise();
        scl_fall();
    endtask

    task automatic start_cond();
        if (!scl_in) begin
            sda_m = 1'b1; tick();
            scl_rise();
        end
        sda_m = 1'b0; tick(); tick();
        scl_fall();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; tick();
        scl_rise();
        sda_m = 1'b1; tick(); tick();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        acked = sda_oe;
        send_bit(1'b1);
    endtask

    task automatic read_byte(input logic master_ack, input logic [7:0] next_tx, output logic [7:0] got);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick();
            got[i] = sda_in;
            scl_rise();
            scl_fall();
        end
        tx_data = next_tx;
        send_bit(~master_ack);
    endtask

    task automatic test_reset();
        preset = 1'b1; tick(); tick();
        preset = 1'b0; tick();
        total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); else passed++;
        total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else passed++;
        total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else passed++;
        total++; if (tx_load !== 1'b0) $display("FAIL reset_tx_load: got %b expected 0", tx_load); else passed++;
        total++; if (addr_match !== 1'b0) $display("FAIL reset_addr_match: got %b expected 0", addr_match); else passed++;
        total++; if (rw !== 1'b0) $display("FAIL reset_rw: got %b expected 0", rw); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_write();
        logic a;
        int rxv0, am0;
        rxv0 = rxv_cnt; am0 = am_cnt;
        start_cond();
        total++; if (busy !== 1'b1) $display("FAIL write_busy_after_start: got %b expected 1", busy); else passed++;
        send_byte(8'h54, a);
        total++; if (a !== 1'b1) $display("FAIL write_addr_ack: got %b expected 1", a); else passed++;
        total++; if (am_cnt - am0 !== 1) $display("FAIL write_addr_match_pulses: got %0d expected 1", am_cnt - am0); else passed++;
        total++; if (rw !== 1'b0) $display("FAIL write_rw: got %b expected 0", rw); else passed++;
        send_byte(8'hA5, a);
        total++; if (a !== 1'b1) $display("FAIL write_data_ack: got %b expected 1", a); else passed++;
        total++; if (rx_data !== 8'hA5) $display("FAIL write_rx_data: got %h expected a5", rx_data); else passed++;
        total++; if (rxv_cnt - rxv0 !== 1) $display("FAIL write_rx_valid_pulses: got %0d expected 1", rxv_cnt - rxv0); else passed++;
        stop_cond();
        total++; if (busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b expected 0", busy); else passed++;
        total++; if (sda_oe !== 1'b0) $display("FAIL write_sda_oe_after_stop: got %b expected 0", sda_oe); else passed++;
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] g;
        int txl0;
        txl0 = txl_cnt;
        tx_data = 8'h3C;
        start_cond();
        send_byte(8'h55, a);
        total++; if (a !== 1'b1) $display("FAIL read_addr_ack: got %b expected 1", a); else passed++;
        total++; if (rw !== 1'b1) $display("FAIL read_rw: got %b expected 1", rw); else passed++;
        read_byte(1'b1, 8'hC3, g);
        total++; if (g !== 8'h3C) $display("FAIL read_byte0: got %h expected 3c", g); else passed++;
        read_byte(1'b0, 8'h00, g);
        total++; if (g !== 8'hC3) $display("FAIL read_byte1: got %h expected c3", g); else passed++;
        total++; if (txl_cnt - txl0 !== 2) $display("FAIL read_tx_load_pulses: got %0d expected 2", txl_cnt - txl0); else passed++;
        total++; if (sda_oe !== 1'b0) $display("FAIL read_wait_stop_sda_oe: got %b expected 0", sda_oe); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL read_wait_stop_busy: got %b expected 1", busy); else passed++;
        stop_cond();
        total++; if (busy !== 1'b0) $display("FAIL read_busy_after_stop: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_bad_addr();
        logic a;
        int rxv0, am0, oe0;
        rxv0 = rxv_cnt; am0 = am_cnt; oe0 = oe_cnt;
        start_cond();
        send_byte(8'h56, a);
        total++; if (a !== 1'b0) $display("FAIL badaddr_ack: got %b expected 0", a); else passed++;
        send_byte(8'h99, a);
        total++; if (a !== 1'b0) $display("FAIL badaddr_data_ack: got %b expected 0", a); else passed++;
        total++; if (oe_cnt - oe0 !== 0) $display("FAIL badaddr_sda_oe_cycles: got %0d expected 0", oe_cnt - oe0); else passed++;
        total++; if (rxv_cnt - rxv0 !== 0) $display("FAIL badaddr_rx_valid: got %0d expected 0", rxv_cnt - rxv0); else passed++;
        total++; if (am_cnt - am0 !== 0) $display("FAIL badaddr_addr_match: got %0d expected 0", am_cnt - am0); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL badaddr_busy: got %b expected 1", busy); else passed++;
        stop_cond();
    endtask

    task automatic test_repeated_start();
        logic a;
        logic [7:0] g;
        int rxv0;
        rxv0 = rxv_cnt;
        start_cond();
        send_byte(8'h54, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        tx_data = 8'h5A;
        start_cond();
        send_byte(8'h55, a);
        total++; if (a !== 1'b1) $display("FAIL rstart_addr_ack: got %b expected 1", a); else passed++;
        total++; if (rw !== 1'b1) $display("FAIL rstart_rw: got %b expected 1", rw); else passed++;
        read_byte(1'b0, 8'h00, g);
        total++; if (g !== 8'h5A) $display("FAIL rstart_read_byte: got %h expected 5a", g); else passed++;
        total++; if (rxv_cnt - rxv0 !== 0) $display("FAIL rstart_rx_valid: got %0d expected 0", rxv_cnt - rxv0); else passed++;
        stop_cond();
    endtask

    task automatic test_reset_during_ack();
        logic a;
        logic [7:0] b;
        int am0, oe0;
        b = 8'h54;
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        total++; if (sda_oe !== 1'b1) $display("FAIL rst_ack_driven: got %b expected 1", sda_oe); else passed++;
        #2 preset = 1'b1;
        #1;
        total++; if (sda_oe !== 1'b0) $display("FAIL rst_async_sda_oe: got %b expected 0", sda_oe); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b expected 0", busy); else passed++;
        tick();
        preset = 1'b0;
        tick();
        am0 = am_cnt; oe0 = oe_cnt;
        send_byte(8'h54, a);
        total++; if (a !== 1'b0) $display("FAIL rst_no_start_ack: got %b expected 0", a); else passed++;
        total++; if (am_cnt - am0 !== 0) $display("FAIL rst_no_start_match: got %0d expected 0", am_cnt - am0); else passed++;
        total++; if (oe_cnt - oe0 !== 0) $display("FAIL rst_no_start_sda_oe: got %0d expected 0", oe_cnt - oe0); else passed++;
        stop_cond();
        start_cond();
        send_byte(8'h54, a);
        total++; if (a !== 1'b1) $display("FAIL rst_recover_ack: got %b expected 1", a); else passed++;
        stop_cond();
    endtask

    task automatic test_gen_call();
        logic a;
        int am0, rxv0;
        am0 = am_cnt; rxv0 = rxv_cnt;
        start_cond();
        send_byte(8'h00, a);
        total++; if (a !== GEN) $display("FAIL gencall_addr_ack: got %b expected %b", a, GEN); else passed++;
        total++; if (am_cnt - am0 !== int'(GEN)) $display("FAIL gencall_addr_match: got %0d expected %0d", am_cnt - am0, int'(GEN)); else passed++;
        send_byte(8'h11, a);
        total++; if (a !== GEN) $display("FAIL gencall_data_ack: got %b expected %b", a, GEN); else passed++;
        total++; if (rxv_cnt - rxv0 !== int'(GEN)) $display("FAIL gencall_rx_valid: got %0d expected %0d", rxv_cnt - rxv0, int'(GEN)); else passed++;
        total++; if (rw !== 1'b0) $display("FAIL gencall_rw: got %b expected 0", rw); else passed++;
        stop_cond();
        am0 = am_cnt;
        start_cond();
        send_byte(8'h01, a);
        total++; if (a !== 1'b0) $display("FAIL addr01_ack: got %b expected 0", a); else passed++;
        total++; if (am_cnt - am0 !== 0) $display("FAIL addr01_match: got %0d expected 0", am_cnt - am0); else passed++;
        stop_cond();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_repeated_start();
        test_reset_during_ack();
        test_gen_call();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
